// File: rtl/cache_arbiter.sv
// Two-requester round-robin front end for a single-ported cache with a registered hit/data return.
// One access is in flight at a time; writes are abandoned if the cache does not accept within WRITE_TIMEOUT cycles.
module cache_arbiter #(
  parameter int WRITE_TIMEOUT = 4,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              hit_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_val,
  output logic              c_read,
  output logic              c_write,
  input  logic              c_hit,
  input  logic [DATA_W-1:0] c_out_val
);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE
  } state_t;

  localparam logic [3:0] TMO = 4'(WRITE_TIMEOUT);

  state_t            state_q;
  logic              gnt_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;
  logic              hit_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done0_q;
  logic              done1_q;
  logic              c_read_q;
  logic              c_write_q;

  logic              pick1;
  logic              any_req;
  logic [3:0]        cnt_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    any_req   = req0 | req1;
    pick1     = req1 & (~req0 | ~last_q);
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
    cnt_d     = cnt_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= 4'd0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      c_read_q  <= 1'b0;
      c_write_q <= 1'b0;
    end else begin
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      c_read_q  <= 1'b0;
      c_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= pick1;
            last_q  <= pick1;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt_q   <= 4'd0;
            if (sel_we) begin
              state_q   <= WR_ISSUE;
              c_write_q <= 1'b1;
            end else begin
              state_q  <= RD_ISSUE;
              c_read_q <= 1'b1;
            end
          end
        end
        RD_ISSUE: state_q <= RD_WAIT;
        RD_WAIT: begin
          hit_q   <= c_hit;
          rdata_q <= c_out_val;
          done0_q <= ~gnt_q;
          done1_q <= gnt_q;
          state_q <= DONE;
        end
        WR_ISSUE: state_q <= WR_WAIT;
        // A hit on the final wait cycle still counts as accepted.
        WR_WAIT: begin
          if (c_hit) begin
            hit_q   <= 1'b1;
            done0_q <= ~gnt_q;
            done1_q <= gnt_q;
            state_q <= DONE;
          end else if (cnt_d == TMO) begin
            hit_q   <= 1'b0;
            done0_q <= ~gnt_q;
            done1_q <= gnt_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done0   = done0_q;
  assign done1   = done1_q;
  assign hit_o   = hit_q;
  assign rdata_o = rdata_q;
  assign c_addr  = addr_q;
  assign c_val   = wdata_q;
  assign c_read  = c_read_q;
  assign c_write = c_write_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a registered cache model answers strobes,
// expected completions are queued at issue time and compared on each done pulse.
module tb_cache_arbiter;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        done0, done1, hit_o, c_read, c_write;
  logic [31:0] rdata_o, c_val;
  logic [7:0]  c_addr;
  logic        c_hit = 1'b0;
  logic [31:0] c_out_val = '0;

  always #5 clock = ~clock;

  cache_arbiter #(.WRITE_TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .hit_o(hit_o), .rdata_o(rdata_o),
    .c_addr(c_addr), .c_val(c_val), .c_read(c_read), .c_write(c_write),
    .c_hit(c_hit), .c_out_val(c_out_val)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cache model: registered response one cycle after the strobe cycle.
  logic [31:0] mem [256];
  logic        vld [256];
  int          wr_lat = 1;
  logic        saw_rd = 1'b0, saw_wr = 1'b0;
  logic [7:0]  sa = '0, waddr = '0;
  logic [31:0] sv = '0, wval = '0;
  bit          wpend = 1'b0;
  int          wage = 0, cur_lat = 0;

  always @(negedge clock) begin
    saw_rd = c_read;
    saw_wr = c_write;
    sa     = c_addr;
    sv     = c_val;
  end

  always @(posedge clock) begin
    #1;
    c_hit     = 1'b0;
    c_out_val = $urandom;
    if (!reset_n) begin
      wpend = 1'b0;
    end else begin
      if (saw_rd) begin
        c_hit     = vld[sa];
        c_out_val = mem[sa];
      end
      if (saw_wr) begin
        wpend = 1'b1; wage = 0; waddr = sa; wval = sv; cur_lat = wr_lat;
      end
      if (wpend) begin
        wage++;
        if (wage == cur_lat) begin
          c_hit = 1'b1;
          mem[waddr] = wval;
          vld[waddr] = 1'b1;
          wpend = 1'b0;
        end else if (wage > 15) begin
          wpend = 1'b0;
        end
      end
    end
  end

  typedef struct {
    int          id;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          hit;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] rd_hold = '0;

  // lat = cycles from the strobe cycle to the done cycle (read: done in 3rd cycle of the access).
  task automatic expect_op(input int id, input bit wr, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    e.id = id; e.wr = wr; e.addr = a; e.data = d;
    if (wr) begin
      e.hit   = (wr_lat >= 1) && (wr_lat <= TMO);
      e.lat   = e.hit ? wr_lat + 1 : TMO + 1;
      e.rdata = '0;
    end else begin
      e.hit   = vld[a];
      e.rdata = mem[a];
      e.lat   = 2;
    end
    sbq.push_back(e);
  endtask

  int cyc = 0, strobes = 0, strobe_cyc = 0;

  always @(negedge clock) begin
    cyc++;
    if (reset_n) begin
      if (c_read || c_write) begin
        check("strobe_excl", 32'(c_read & c_write), 32'd0);
        strobes++;
        strobe_cyc = cyc;
        if (sbq.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
        else begin
          check("strobe_kind", 32'(c_write), 32'(sbq[0].wr));
          check("c_addr", 32'(c_addr), 32'(sbq[0].addr));
          if (sbq[0].wr) check("c_val", c_val, sbq[0].data);
        end
      end
      if (done0 || done1) begin
        check("done_overlap", 32'(done0 & done1), 32'd0);
        if (sbq.size() == 0) check("done_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = sbq.pop_front();
          check("done_id", 32'(done1), 32'(mon_e.id));
          check("hit", 32'(hit_o), 32'(mon_e.hit));
          check("latency", 32'(cyc - strobe_cyc), 32'(mon_e.lat));
          check("strobe_count", 32'(strobes), 32'd1);
          if (mon_e.wr) check("rdata_hold_wr", rdata_o, rd_hold);
          else begin
            if (mon_e.hit) check("rdata", rdata_o, mon_e.rdata);
            rd_hold = mon_e.rdata;
          end
        end
        strobes = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    sbq.delete();
    strobes = 0;
    rd_hold = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_op(input int id, input bit wr, input logic [7:0] a, input logic [31:0] d);
    bit got = 1'b0;
    expect_op(id, wr, a, d);
    @(negedge clock);
    if (id == 1) begin we1 = wr; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else         begin we0 = wr; addr0 = a; wdata0 = d; req0 = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if ((id == 1) ? done1 : done0) begin got = 1'b1; break; end
    end
    if (id == 1) req1 = 1'b0; else req0 = 1'b0;
    if (!got) begin
      check("op_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int ndone;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hA500_0000 | 32'(i);
      vld[i] = 1'b0;
    end
    mem[8'h10] = 32'hDEADBEEF;
    vld[8'h10] = 1'b1;

    #3;
    check("rst_done0",   32'(done0),   32'd0);
    check("rst_done1",   32'(done1),   32'd0);
    check("rst_hit",     32'(hit_o),   32'd0);
    check("rst_c_read",  32'(c_read),  32'd0);
    check("rst_c_write", 32'(c_write), 32'd0);
    check("rst_rdata",   rdata_o,      32'd0);
    check("rst_c_addr",  32'(c_addr),  32'd0);
    check("rst_c_val",   c_val,        32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    run_op(0, 1'b0, 8'h10, 32'd0);
    wr_lat = 2;
    run_op(1, 1'b1, 8'h22, 32'h12345678);
    run_op(1, 1'b0, 8'h22, 32'd0);
    wr_lat = 0;
    run_op(0, 1'b1, 8'h40, 32'hCAFEF00D);
    run_op(0, 1'b0, 8'h40, 32'd0);
    wr_lat = TMO;
    run_op(1, 1'b1, 8'h41, 32'h0BADCAFE);
    wr_lat = 1;
    run_op(0, 1'b1, 8'h42, 32'h55AA55AA);
    run_op(1, 1'b0, 8'h41, 32'd0);

    for (int k = 0; k < 10; k++) begin
      wr_lat = $urandom_range(0, TMO);
      run_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'(8'h60 + $urandom_range(0, 3)), $urandom);
    end

    // Tie: both held high from reset, expect grants 0,1,0,1.
    do_reset();
    expect_op(0, 1'b0, 8'h10, 32'd0);
    expect_op(1, 1'b0, 8'h22, 32'd0);
    expect_op(0, 1'b0, 8'h10, 32'd0);
    expect_op(1, 1'b0, 8'h22, 32'd0);
    @(negedge clock);
    we0 = 1'b0; we1 = 1'b0; addr0 = 8'h10; addr1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    ndone = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done0 || done1) ndone++;
      if (ndone >= 4) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie_dones", 32'(ndone), 32'd4);
    repeat (4) @(negedge clock);
    check("tie_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset while a write waits for the cache.
    wr_lat = 0;
    expect_op(0, 1'b1, 8'h33, 32'h0F0F0F0F);
    @(negedge clock);
    we0 = 1'b1; addr0 = 8'h33; wdata0 = 32'h0F0F0F0F; req0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (c_write) begin got = 1'b1; break; end
    end
    check("midrst_strobe_seen", 32'(got), 32'd1);
    repeat (2) @(negedge clock);
    #2;
    reset_n = 1'b0;
    req0 = 1'b0;
    #1;
    check("midrst_c_write", 32'(c_write), 32'd0);
    check("midrst_done0",   32'(done0),   32'd0);
    check("midrst_done1",   32'(done1),   32'd0);
    check("midrst_c_addr",  32'(c_addr),  32'd0);
    sbq.delete();
    strobes = 0;
    rd_hold = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    run_op(0, 1'b0, 8'h10, 32'd0);

    // Request withdrawn right after grant still completes.
    expect_op(1, 1'b0, 8'h22, 32'd0);
    @(negedge clock);
    we1 = 1'b0; addr1 = 8'h22; req1 = 1'b1;
    @(negedge clock);
    req1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done1) begin got = 1'b1; break; end
    end
    check("dropped_req_done", 32'(got), 32'd1);

    repeat (4) @(negedge clock);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
